npc_fetch: RTL

- Instruction-fetch and next-PC stage of mySoC.
- Holds the architectural PC and issues requests to instruction ROM over a req/ack handshake.
- Presents fetched instructions to decode with valid/ready.
- Consumes the execute-stage branch flag (alu_f), ALU sum (alu_c) and immediate to redirect the PC on taken branches, jal and jalr.

---
 rtl/npc_fetch_pkg.sv | 22 ++
 rtl/npc_fetch_target.sv | 32 +++
 rtl/npc_fetch.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/npc_fetch_pkg.sv
// Shared definitions for the fetch / next-PC stage: next-PC opcodes,
// FSM state encodings and a word-alignment helper.
package npc_fetch_pkg;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_JAL  = 2'd2;
    localparam logic [1:0] NPC_JALR = 2'd3;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } npc_state_t;

    // Clear the byte-offset bits of an address.
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/npc_fetch_target.sv
// Combinational redirect decision and branch/jump target computation.
module npc_fetch_target
    import npc_fetch_pkg::*;
(
    input  logic        ex_valid,
    input  logic [1:0]  npc_op,
    input  logic [31:0] ex_pc,
    input  logic [31:0] imm,
    input  logic [31:0] alu_c,
    input  logic        alu_f,
    output logic        redirect,
    output logic [31:0] target
);

    // Decode the executing instruction's next-PC operation.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        redirect = 1'b0;
        target   = ex_pc + imm;
        case (npc_op)
            NPC_PC4:  redirect = 1'b0;
            NPC_BR:   redirect = ex_valid & alu_f;
            NPC_JAL:  redirect = ex_valid;
            NPC_JALR: begin
                redirect = ex_valid;
                target   = alu_c & ~32'h1;
            end
            default:  redirect = 1'b0;
        endcase
    end

endmodule

// File: rtl/npc_fetch.sv
// Instruction fetch and next-PC stage. Holds the PC, fetches from the
// instruction ROM over req/ack and hands words to decode over valid/ready.
// Build option: NPC_MISALIGN_CHK_EN halts on a misaligned redirect target;
// without it the target is word-aligned and misalign_err is tied low.
module npc_fetch
    import npc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        ex_valid,
    input  logic [1:0]  npc_op,
    input  logic [31:0] ex_pc,
    input  logic [31:0] imm,
    input  logic [31:0] alu_c,
    input  logic        alu_f,
    output logic        irom_req,
    output logic [31:0] irom_addr,
    input  logic        irom_ack,
    input  logic [31:0] irom_inst,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        misalign_err
);

    npc_state_t  state;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        err_q;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] new_tgt;
    logic        bad;
    logic        take;

    npc_fetch_target u_target (
        .ex_valid (ex_valid),
        .npc_op   (npc_op),
        .ex_pc    (ex_pc),
        .imm      (imm),
        .alu_c    (alu_c),
        .alu_f    (alu_f),
        .redirect (redirect),
        .target   (target)
    );

`ifdef NPC_MISALIGN_CHK_EN
    assign new_tgt      = target;
    assign bad          = redirect & (target[1:0] != 2'b00);
    assign misalign_err = err_q;
`else
    assign new_tgt      = align_word(target);
    assign bad          = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // A redirect is only honoured while no misalignment has been flagged.
    assign take = redirect & ~bad & ~err_q;

    // Fetch FSM with registered ROM request and decode outputs.
    always_ff @(posedge cpu_clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (cpu_rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            tgt       <= '0;
            err_q     <= 1'b0;
            irom_req  <= 1'b0;
            irom_addr <= RESET_PC;
            if_valid  <= 1'b0;
            if_inst   <= '0;
            if_pc     <= '0;
            if_pc4    <= '0;
        end else begin
            if (bad) err_q <= 1'b1;
            case (state)
                FETCH: begin
                    if (!irom_req) begin
                        if (bad) begin
                            state <= HALT;
                        end else begin
                            irom_req  <= 1'b1;
                            irom_addr <= take ? new_tgt : pc;
                            if (take) pc <= new_tgt;
                        end
                    end else if (irom_ack) begin
                        irom_req <= 1'b0;
                        if (bad) begin
                            state <= HALT;
                        end else if (take) begin
                            pc <= new_tgt;
                        end else begin
                            if_inst  <= irom_inst;
                            if_pc    <= pc;
                            if_pc4   <= pc + 32'd4;
                            pc       <= pc + 32'd4;
                            if_valid <= 1'b1;
                            state    <= HOLD;
                        end
                    end else if (redirect) begin
                        if (take) tgt <= new_tgt;
                        state <= DRAIN;
                    end
                end
                HOLD: begin
                    if (bad) begin
                        if_valid <= 1'b0;
                        state    <= HALT;
                    end else if (take) begin
                        if_valid  <= 1'b0;
                        pc        <= new_tgt;
                        irom_req  <= 1'b1;
                        irom_addr <= new_tgt;
                        state     <= FETCH;
                    end else if (if_ready) begin
                        if_valid  <= 1'b0;
                        irom_req  <= 1'b1;
                        irom_addr <= pc;
                        state     <= FETCH;
                    end
                end
                DRAIN: begin
                    if (irom_ack) begin
                        irom_req <= 1'b0;
                        if (err_q || bad) begin
                            state <= HALT;
                        end else begin
                            pc    <= take ? new_tgt : tgt;
                            state <= FETCH;
                        end
                    end else if (take) begin
                        tgt <= new_tgt;
                    end
                end
                HALT: begin
                    irom_req <= 1'b0;
                    if_valid <= 1'b0;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
